// File: rtl/sym_err_counter_if.sv
// Bus bundle for sym_err_counter: symbol-rate inputs, measurement control and results.
// The DUT takes the slave modport and the driver takes the master modport.
interface sym_err_counter_if #(
    parameter int SYM_W = 4,
    parameter int DEPTH = 64,
    parameter int CNT_W = 24
);
    localparam int DLY_W = $clog2(DEPTH);

    logic             clk_en;
    logic             start;
    logic [DLY_W-1:0] delay;
    logic [CNT_W-1:0] window_len;
    logic [SYM_W-1:0] ref_sym;
    logic [SYM_W-1:0] rx_sym;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sym_count;
    logic [CNT_W-1:0] sym_err_count;
    logic [CNT_W-1:0] bit_err_count;

    modport master (
        output clk_en, start, delay, window_len, ref_sym, rx_sym,
        input  busy, done, sym_count, sym_err_count, bit_err_count
    );

    modport slave (
        input  clk_en, start, delay, window_len, ref_sym, rx_sym,
        output busy, done, sym_count, sym_err_count, bit_err_count
    );
endinterface

// File: rtl/sym_err_counter.sv
// Symbol/bit error counter: delays ref_sym to line up with rx_sym, then counts mismatches over a window.
// Define SEC_BIT_ERR_EN to build the popcount path; otherwise bit_err_count is constant 0.
module sym_err_counter #(
    parameter int SYM_W = 4,
    parameter int DEPTH = 64,
    parameter int CNT_W = 24
) (
    input  logic               clk,
    input  logic               reset,
    sym_err_counter_if.slave   bus
);
    localparam int DLY_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_MEASURE, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [SYM_W-1:0] ref_mem [DEPTH];
    logic [DLY_W-1:0] wr_ptr_q;
    logic [DLY_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [DLY_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0] sym_err_q, sym_err_d;
    logic             busy_q, done_q;
    logic [DLY_W-1:0] rd_addr;
    logic [SYM_W-1:0] aligned_ref;
    logic             mismatch;
    logic [DLY_W:0]   fill_next;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    // Reference history keeps running in every state so FILL only has to wait out the delay.
    always_ff @(posedge clk) begin
        if (bus.clk_en) begin
            ref_mem[wr_ptr_q] <= bus.ref_sym;
        end
    end

    assign rd_addr     = wr_ptr_q - delay_q;
    assign aligned_ref = (delay_q == '0) ? bus.ref_sym : ref_mem[rd_addr];
    assign mismatch    = (aligned_ref != bus.rx_sym);
    assign fill_next   = {1'b0, fill_cnt_q} + {{DLY_W{1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        delay_d    = delay_q;
        win_d      = win_q;
        sym_cnt_d  = sym_cnt_q;
        sym_err_d  = sym_err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d    = S_FILL;
                    delay_d    = bus.delay;
                    win_d      = bus.window_len;
                    fill_cnt_d = '0;
                    sym_cnt_d  = '0;
                    sym_err_d  = '0;
                end
            end
            S_FILL: begin
                // Leaving after delay_q enables (one when delay_q is 0) makes the first compare see post-start data.
                if (bus.clk_en) begin
                    fill_cnt_d = fill_next[DLY_W-1:0];
                    if (fill_next >= {1'b0, delay_q}) begin
                        state_d = (win_q == '0) ? S_DONE : S_MEASURE;
                    end
                end
            end
            S_MEASURE: begin
                if (bus.clk_en) begin
                    sym_cnt_d = sat_add(sym_cnt_q, CNT_W'(1));
                    sym_err_d = sat_add(sym_err_q, CNT_W'(mismatch));
                    if (sym_cnt_d == win_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            delay_q    <= '0;
            win_q      <= '0;
            sym_cnt_q  <= '0;
            sym_err_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            delay_q    <= delay_d;
            win_q      <= win_d;
            sym_cnt_q  <= sym_cnt_d;
            sym_err_q  <= sym_err_d;
            busy_q     <= (state_d == S_FILL) || (state_d == S_MEASURE);
            done_q     <= (state_d == S_DONE) && (state_q != S_DONE);
            if (bus.clk_en) begin
                wr_ptr_q <= wr_ptr_q + DLY_W'(1);
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.sym_count     = sym_cnt_q;
    assign bus.sym_err_count = sym_err_q;

`ifdef SEC_BIT_ERR_EN
    localparam int POP_W = $clog2(SYM_W + 1);

    logic [SYM_W-1:0] diff;
    logic [POP_W-1:0] pop;
    logic [CNT_W-1:0] bit_err_q;
    logic             start_acc;
    logic             compare;

    assign diff      = aligned_ref ^ bus.rx_sym;
    assign start_acc = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign compare   = bus.clk_en && (state_q == S_MEASURE);

    always_comb begin
        pop = '0;
        for (int i = 0; i < SYM_W; i++) begin
            pop = pop + POP_W'(diff[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_err_q <= '0;
        end else if (start_acc) begin
            bit_err_q <= '0;
        end else if (compare) begin
            bit_err_q <= sat_add(bit_err_q, CNT_W'(pop));
        end
    end

    assign bus.bit_err_count = bit_err_q;
`else
    assign bus.bit_err_count = '0;
`endif

endmodule

// File: tb/tb_sym_err_counter.sv
// Self-checking bench for sym_err_counter: a 24-bit/64-deep instance for the main windows and a
// 4-bit/8-deep instance for counter saturation; results are scored at each done pulse.
module tb_sym_err_counter;
    localparam int N = 16384;
`ifdef SEC_BIT_ERR_EN
    localparam int BE_ON = 1;
`else
    localparam int BE_ON = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sym_err_counter_if #(.SYM_W(4), .DEPTH(64), .CNT_W(24)) bif ();
    sym_err_counter_if #(.SYM_W(4), .DEPTH(8),  .CNT_W(4))  sif ();

    sym_err_counter #(.SYM_W(4), .DEPTH(64), .CNT_W(24)) u_big (
        .clk(clk), .reset(reset), .bus(bif)
    );
    sym_err_counter #(.SYM_W(4), .DEPTH(8), .CNT_W(4)) u_small (
        .clk(clk), .reset(reset), .bus(sif)
    );

    typedef struct { int sc; int se; int be; } exp_t;
    typedef struct { int which; int d; int w; int mode; bit busy_start; int exp_se; int exp_be; } vec_t;

    exp_t q_big[$];
    exp_t q_small[$];
    int checks = 0;
    int errors = 0;
    logic [3:0] hist [N];
    int e = 0;
    vec_t tbl [9];

    task automatic check(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic int sat(int v, int cw);
        int mx = (1 << cw) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int pop4(logic [3:0] v);
        return BE_ON * (int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]));
    endfunction

    function automatic int dut_done(int which);  return which != 0 ? int'(sif.done) : int'(bif.done); endfunction
    function automatic int dut_busy(int which);  return which != 0 ? int'(sif.busy) : int'(bif.busy); endfunction
    function automatic int dut_sc(int which);    return which != 0 ? int'(sif.sym_count) : int'(bif.sym_count); endfunction
    function automatic int dut_se(int which);    return which != 0 ? int'(sif.sym_err_count) : int'(bif.sym_err_count); endfunction
    function automatic int dut_be(int which);    return which != 0 ? int'(sif.bit_err_count) : int'(bif.bit_err_count); endfunction

    // One clock: drive symbol inputs to both instances, log enabled refs into the model history.
    task automatic drive(bit en, logic [3:0] r, logic [3:0] x);
        bif.clk_en = en;  sif.clk_en = en;
        bif.ref_sym = r;  sif.ref_sym = r;
        bif.rx_sym = x;   sif.rx_sym = x;
        if (en) begin
            hist[e & (N-1)] = r;
            e++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_junk();
        bif.delay = 6'($urandom);  bif.window_len = 24'($urandom);
        sif.delay = 3'($urandom);  sif.window_len = 4'($urandom);
    endtask

    task automatic pulse_start(int which, int d, int w);
        bif.delay = 6'(d);  bif.window_len = 24'(w);
        sif.delay = 3'(d);  sif.window_len = 4'(w);
        if (which != 0) sif.start = 1'b1; else bif.start = 1'b1;
        drive(1'b0, 4'($urandom), 4'($urandom));
        bif.start = 1'b0;  sif.start = 1'b0;
        set_junk();
    endtask

    task automatic run(vec_t v);
        int cw = (v.which != 0) ? 4 : 24;
        int fillen = (v.d > 0) ? v.d : 1;
        int jlast = fillen + v.w - 1;
        int sc = 0, se = 0, be = 0;
        exp_t x;
        logic [3:0] r, a, rx;
        x = '{0, 0, 0};
        pulse_start(v.which, v.d, v.w);
        check("busy_after_start", dut_busy(v.which), 1);
        for (int j = 0; j <= jlast; j++) begin
            if ($urandom_range(0, 3) == 0) drive(1'b0, 4'($urandom), 4'($urandom));
            r = 4'($urandom);
            a = (v.d == 0) ? r : hist[(e - v.d) & (N-1)];
            case (v.mode)
                0:       rx = hist[(e - 7) & (N-1)];
                1:       rx = (j >= fillen && (j - fillen) % 4 == 3) ? (a ^ 4'd1) : a;
                2:       rx = ~a;
                default: rx = 4'($urandom);
            endcase
            if (j >= fillen) begin
                sc = sat(sc + 1, cw);
                se = sat(se + int'(a != rx), cw);
                be = sat(be + pop4(a ^ rx), cw);
            end
            if (j == jlast) begin
                x.sc = sc;
                x.se = (v.exp_se >= 0) ? v.exp_se : se;
                x.be = (v.exp_be >= 0) ? v.exp_be : be;
                if (v.which != 0) q_small.push_back(x); else q_big.push_back(x);
            end
            if (v.busy_start && j == 1) begin
                set_junk();
                if (v.which != 0) sif.start = 1'b1; else bif.start = 1'b1;
            end
            drive(1'b1, r, rx);
            bif.start = 1'b0;  sif.start = 1'b0;
            check("done_timing", dut_done(v.which), int'(j == jlast));
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'($urandom), 4'($urandom));
            if (k == 0) begin
                check("done_one_cycle", dut_done(v.which), 0);
                check("busy_after_done", dut_busy(v.which), 0);
            end
        end
        check("sym_count_hold", dut_sc(v.which), x.sc);
        check("sym_err_hold", dut_se(v.which), x.se);
        check("bit_err_hold", dut_be(v.which), x.be);
        $display("run which=%0d delay=%0d window=%0d mode=%0d -> sym=%0d sym_err=%0d bit_err=%0d",
                 v.which, v.d, v.w, v.mode, x.sc, x.se, x.be);
    endtask

    exp_t mb, ms;
    always @(negedge clk) begin
        if (bif.done) begin
            if (q_big.size() == 0) begin
                checks++; errors++;
                $display("FAIL big_unexpected_done actual 1 required 0");
            end else begin
                mb = q_big.pop_front();
                check("big_sym_count", bif.sym_count, mb.sc);
                check("big_sym_err_count", bif.sym_err_count, mb.se);
                check("big_bit_err_count", bif.bit_err_count, mb.be);
            end
        end
        if (sif.done) begin
            if (q_small.size() == 0) begin
                checks++; errors++;
                $display("FAIL small_unexpected_done actual 1 required 0");
            end else begin
                ms = q_small.pop_front();
                check("small_sym_count", sif.sym_count, ms.sc);
                check("small_sym_err_count", sif.sym_err_count, ms.se);
                check("small_bit_err_count", sif.bit_err_count, ms.be);
            end
        end
    end

    initial begin
        bif.start = 1'b0;  sif.start = 1'b0;
        bif.clk_en = 1'b0; sif.clk_en = 1'b0;
        bif.delay = '0;    sif.delay = '0;
        bif.window_len = '0; sif.window_len = '0;
        bif.ref_sym = '0;  sif.ref_sym = '0;
        bif.rx_sym = '0;   sif.rx_sym = '0;

        //               which d   w     mode busy exp_se exp_be
        tbl[0] = '{0, 7,  4096, 0, 1'b0, 0,  0};
        tbl[1] = '{0, 6,  4096, 0, 1'b0, -1, -1};
        tbl[2] = '{0, 0,  100,  1, 1'b0, 25, 25 * BE_ON};
        tbl[3] = '{0, 3,  0,    3, 1'b1, 0,  0};
        tbl[4] = '{0, 0,  0,    3, 1'b0, 0,  0};
        tbl[5] = '{0, 63, 50,   3, 1'b0, -1, -1};
        tbl[6] = '{0, 1,  10,   3, 1'b1, -1, -1};
        tbl[7] = '{1, 2,  15,   2, 1'b0, 15, 15 * BE_ON};
        tbl[8] = '{1, 7,  15,   3, 1'b0, -1, -1};

        drive(1'b0, 4'd0, 4'd0);
        drive(1'b0, 4'd0, 4'd0);
        reset = 1'b0;
        for (int w = 0; w < 2; w++) begin
            check("reset_busy", dut_busy(w), 0);
            check("reset_done", dut_done(w), 0);
            check("reset_sym_count", dut_sc(w), 0);
            check("reset_sym_err", dut_se(w), 0);
            check("reset_bit_err", dut_be(w), 0);
        end
        for (int k = 0; k < 80; k++) drive(1'b1, 4'($urandom), 4'($urandom));
        check("idle_busy", dut_busy(0), 0);
        check("idle_sym_count", dut_sc(0), 0);
        $display("reset and idle warm-up complete");

        // Reset in the middle of a 1000-symbol window, then a clean full window.
        pulse_start(0, 2, 1000);
        for (int k = 0; k < 502; k++) drive(1'b1, 4'($urandom), 4'($urandom));
        bif.clk_en = 1'b0; sif.clk_en = 1'b0;
        reset = 1'b1;
        #1;
        check("midreset_busy", dut_busy(0), 0);
        check("midreset_done", dut_done(0), 0);
        check("midreset_sym_count", dut_sc(0), 0);
        check("midreset_sym_err", dut_se(0), 0);
        check("midreset_bit_err", dut_be(0), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("reset mid-measure applied after 500 symbols");
        run('{0, 2, 1000, 3, 1'b0, -1, -1});

        for (int i = 0; i < 9; i++) run(tbl[i]);

        drive(1'b0, 4'd0, 4'd0);
        check("big_queue_empty", q_big.size(), 0);
        check("small_queue_empty", q_small.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
